// File: rtl/phase_freq_detector_fp_int_pkg.sv
// Shared types and constants for the phase-frequency detector.
// The FSM state encoding and the saturation limits live here.
package pfd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_BOTH = 2'b11
  } pfd_state_e;

  localparam int PFD_WIDTH_W = 16;
  localparam int PFD_ERR_W   = 16;

  localparam logic [PFD_WIDTH_W-1:0] PFD_WIDTH_MAX = 16'hFFFF;
  localparam logic [PFD_ERR_W-1:0]   PFD_ERR_MAX   = 16'h7FFF;

  // The pulse width plus one can reach 65536, so the input is one bit wider.
  function automatic logic [PFD_ERR_W-1:0] sat_err(input logic [PFD_WIDTH_W:0] v);
    logic [PFD_ERR_W-1:0] res;
    if (v > (PFD_WIDTH_W+1)'(PFD_ERR_MAX)) begin
      res = PFD_ERR_MAX;
    end else begin
      res = v[PFD_ERR_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_freq_detector_fp_int_if.sv
// Signal bundle between the PLL model and the phase-frequency detector.
// The detector drives the up/down, phase-error and lock outputs.
interface phase_freq_detector_fp_int_if;

  logic                         input_ref_digital;
  logic                         input_fb_digital;
  logic                         output_up_digital;
  logic                         output_down_digital;
  logic [pfd_pkg::PFD_ERR_W-1:0] output_phase_err_real;
  logic                         output_lock_digital;

  modport master (
    output input_ref_digital,
    output input_fb_digital,
    input  output_up_digital,
    input  output_down_digital,
    input  output_phase_err_real,
    input  output_lock_digital
  );

  modport slave (
    input  input_ref_digital,
    input  input_fb_digital,
    output output_up_digital,
    output output_down_digital,
    output output_phase_err_real,
    output output_lock_digital
  );

endinterface

// File: rtl/phase_freq_detector_fp_int_lock.sv
// Lock detector: counts consecutive comparisons whose |error| fits the window.
// Only instantiated when PFD_LOCK_DETECT_EN is defined.
module pfd_lock_detector
  import pfd_pkg::*;
#(
  parameter int lock_window_param = 4,
  parameter int lock_count_param  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmp_strobe,
  input  logic [PFD_ERR_W-1:0] i_abs_err,
  output logic                 o_lock
);

  localparam logic [31:0] WIN     = 32'(lock_window_param);
  localparam logic [15:0] CNT_MAX = 16'(lock_count_param);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_lock;
  logic        w_lock_nxt;

  // Next in-lock count and flag, updated only on a comparison.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_lock_nxt = r_lock;
    if (i_cmp_strobe) begin
      if ({16'd0, i_abs_err} <= WIN) begin
        if (r_cnt >= CNT_MAX) begin
          w_cnt_nxt = CNT_MAX;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
        w_lock_nxt = (w_cnt_nxt >= CNT_MAX);
      end else begin
        w_cnt_nxt  = 16'd0;
        w_lock_nxt = 1'b0;
      end
    end else begin
      w_cnt_nxt  = r_cnt;
      w_lock_nxt = r_lock;
    end
  end

  // Count and flag registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= 16'd0;
      r_lock <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_lock <= w_lock_nxt;
    end
  end

  assign o_lock = r_lock;

endmodule

// File: rtl/phase_freq_detector_fp_int.sv
// Phase-frequency detector on the system clock: sampled ref/fb edge compare driving
// charge-pump up/down, a signed phase-error word, and lock (macro PFD_LOCK_DETECT_EN).
module phase_freq_detector_fp_int
  import pfd_pkg::*;
#(
  parameter int reset_delay_param = 2,
  parameter int lock_window_param = 4,
  parameter int lock_count_param  = 16
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  phase_freq_detector_fp_int_if.slave  bus
);

  localparam int RD_EFF = (reset_delay_param < 1) ? 1 : reset_delay_param;
  localparam logic [PFD_WIDTH_W-1:0] DLY_LOAD = PFD_WIDTH_W'(RD_EFF - 1);

  if (lock_count_param < 1 || lock_window_param < 0) begin : g_bad_cfg
    $error("phase_freq_detector_fp_int: lock parameters out of range");
  end

  pfd_state_e             r_state;
  pfd_state_e             w_state_nxt;
  logic                   r_armed;
  logic                   r_ref_q;
  logic                   r_fb_q;
  logic                   w_ref_rise;
  logic                   w_fb_rise;
  logic                   w_both_entry;
  logic                   w_pulse_entry;
  logic [PFD_WIDTH_W-1:0] r_dly_cnt;
  logic [PFD_WIDTH_W-1:0] w_dly_nxt;
  logic [PFD_WIDTH_W-1:0] r_width;
  logic [PFD_WIDTH_W-1:0] w_width_nxt;
  logic [PFD_ERR_W-1:0]   w_mag;
  logic [PFD_ERR_W-1:0]   r_err;
  logic [PFD_ERR_W-1:0]   w_err_nxt;
  logic                   r_up;
  logic                   r_down;
  logic                   w_lock;

  // r_armed masks the first clock after reset so an input already high is not an edge.
  always_comb begin
    w_ref_rise = r_armed & bus.input_ref_digital & ~r_ref_q;
    w_fb_rise  = r_armed & bus.input_fb_digital & ~r_fb_q;
  end

  // Next state; edges are ignored while in BOTH.
  always_comb begin
    w_state_nxt   = r_state;
    w_both_entry  = 1'b0;
    w_pulse_entry = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_state_nxt  = ST_BOTH;
          w_both_entry = 1'b1;
        end else if (w_ref_rise) begin
          w_state_nxt   = ST_UP;
          w_pulse_entry = 1'b1;
        end else if (w_fb_rise) begin
          w_state_nxt   = ST_DOWN;
          w_pulse_entry = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_UP: begin
        if (w_fb_rise) begin
          w_state_nxt  = ST_BOTH;
          w_both_entry = 1'b1;
        end else begin
          w_state_nxt = ST_UP;
        end
      end
      ST_DOWN: begin
        if (w_ref_rise) begin
          w_state_nxt  = ST_BOTH;
          w_both_entry = 1'b1;
        end else begin
          w_state_nxt = ST_DOWN;
        end
      end
      ST_BOTH: begin
        if (r_dly_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BOTH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset-delay count, pulse-width count and phase-error capture.
  always_comb begin
    w_dly_nxt   = r_dly_cnt;
    w_width_nxt = r_width;
    w_err_nxt   = r_err;
    w_mag       = sat_err({1'b0, r_width} + (PFD_WIDTH_W+1)'(1));
    if (w_both_entry) begin
      w_dly_nxt = DLY_LOAD;
    end else if (r_state == ST_BOTH && r_dly_cnt != '0) begin
      w_dly_nxt = r_dly_cnt - PFD_WIDTH_W'(1);
    end else begin
      w_dly_nxt = r_dly_cnt;
    end
    if (w_pulse_entry) begin
      w_width_nxt = '0;
    end else if ((r_state == ST_UP || r_state == ST_DOWN) && r_width != PFD_WIDTH_MAX) begin
      w_width_nxt = r_width + PFD_WIDTH_W'(1);
    end else begin
      w_width_nxt = r_width;
    end
    if (w_both_entry) begin
      case (r_state)
        ST_UP:   w_err_nxt = w_mag;
        ST_DOWN: w_err_nxt = PFD_ERR_W'(0) - w_mag;
        default: w_err_nxt = '0;
      endcase
    end else begin
      w_err_nxt = r_err;
    end
  end

  // FSM state and input history.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_ref_q <= 1'b0;
      r_fb_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
      r_ref_q <= bus.input_ref_digital;
      r_fb_q  <= bus.input_fb_digital;
    end
  end

  // Counters and registered outputs, decoded from the next state for one-edge latency.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_dly_cnt <= '0;
      r_width   <= '0;
      r_err     <= '0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      r_dly_cnt <= w_dly_nxt;
      r_width   <= w_width_nxt;
      r_err     <= w_err_nxt;
      r_up      <= (w_state_nxt == ST_UP) || (w_state_nxt == ST_BOTH);
      r_down    <= (w_state_nxt == ST_DOWN) || (w_state_nxt == ST_BOTH);
    end
  end

`ifdef PFD_LOCK_DETECT_EN
  logic [PFD_ERR_W-1:0] w_abs_err;
  assign w_abs_err = (r_state == ST_UP || r_state == ST_DOWN) ? w_mag : '0;

  pfd_lock_detector #(
    .lock_window_param(lock_window_param),
    .lock_count_param (lock_count_param)
  ) u_lock (
    .i_clk       (sys_clk),
    .i_rst       (reset),
    .i_cmp_strobe(w_both_entry),
    .i_abs_err   (w_abs_err),
    .o_lock      (w_lock)
  );
`else
  assign w_lock = 1'b0;
`endif

  assign bus.output_up_digital     = r_up;
  assign bus.output_down_digital   = r_down;
  assign bus.output_phase_err_real = r_err;
  assign bus.output_lock_digital   = w_lock;

endmodule

// File: tb/tb_phase_freq_detector_fp_int.sv
// Bench for phase_freq_detector_fp_int: directed vector table, reset/lock/saturation
// sequences and random stimulus against an event-timing reference model.
module tb_phase_freq_detector_fp_int;

  localparam int RD  = 2;
  localparam int WIN = 4;
  localparam int CNT = 16;
`ifdef PFD_LOCK_DETECT_EN
  localparam bit LOCK_BUILT = 1'b1;
`else
  localparam bit LOCK_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phase_freq_detector_fp_int_if bus();

  phase_freq_detector_fp_int #(
    .reset_delay_param(RD),
    .lock_window_param(WIN),
    .lock_count_param (CNT)
  ) dut (
    .sys_clk(clk),
    .reset  (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: times of the leading edge and of the last comparison.
  int m_n;
  bit m_armed, m_pref, m_pfb;
  int m_lead;      // 0 none, 1 ref leading, 2 fb leading
  int m_lead_t;
  bit m_both;
  int m_both_t;
  int m_err;
  int m_cnt;
  bit m_lock;

  typedef struct packed {
    logic        r;
    logic        f;
    logic        up;
    logic        dn;
    logic [15:0] err;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic f, input logic up, input logic dn,
                              input logic [15:0] err);
    vec_t v;
    v.r = r; v.f = f; v.up = up; v.dn = dn; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: actual=%0h expected=%0h", name, m_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_pref = 1'b0; m_pfb = 1'b0;
    m_lead = 0; m_lead_t = 0; m_both = 1'b0; m_both_t = 0;
    m_err = 0; m_cnt = 0; m_lock = 1'b0;
  endtask

  function automatic int sat(input int v);
    return (v > 32767) ? 32767 : v;
  endfunction

  task automatic judge(input int e);
    int a;
    m_err = e; m_both = 1'b1; m_both_t = m_n; m_lead = 0;
    a = (e < 0) ? -e : e;
    if (a <= WIN) begin
      if (m_cnt < CNT) m_cnt++;
      m_lock = (m_cnt >= CNT);
    end else begin
      m_cnt = 0;
      m_lock = 1'b0;
    end
  endtask

  task automatic model_edge(input bit r, input bit f);
    bit rr, fr;
    m_n++;
    rr = m_armed && r && !m_pref;
    fr = m_armed && f && !m_pfb;
    m_pref = r; m_pfb = f; m_armed = 1'b1;
    if (m_both) begin
      if (m_n >= m_both_t + RD) m_both = 1'b0;
    end else if (m_lead == 0) begin
      if (rr && fr) judge(0);
      else if (rr) begin m_lead = 1; m_lead_t = m_n; end
      else if (fr) begin m_lead = 2; m_lead_t = m_n; end
    end else if (m_lead == 1 && fr) begin
      judge(sat(m_n - m_lead_t));
    end else if (m_lead == 2 && rr) begin
      judge(-sat(m_n - m_lead_t));
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_up"},   16'(bus.output_up_digital),     16'(m_lead == 1 || m_both));
    chk({tag, "_down"}, 16'(bus.output_down_digital),   16'(m_lead == 2 || m_both));
    chk({tag, "_err"},  bus.output_phase_err_real,      16'(m_err));
    chk({tag, "_lock"}, 16'(bus.output_lock_digital),   16'(LOCK_BUILT & m_lock));
  endtask

  task automatic step(input logic r, input logic f);
    @(negedge clk);
    bus.input_ref_digital = r;
    bus.input_fb_digital  = f;
    @(posedge clk);
    model_edge(r, f);
    #1;
    check_model("model");
  endtask

  task automatic do_compare(input bit lead_ref, input int gap);
    step(1'b0, 1'b0);
    for (int i = 0; i < gap; i++) step(lead_ref, !lead_ref);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 16'h0000);
    vecs[1]  = mk(1, 0, 1, 0, 16'h0000);
    vecs[2]  = mk(1, 0, 1, 0, 16'h0000);
    vecs[3]  = mk(1, 0, 1, 0, 16'h0000);
    vecs[4]  = mk(1, 0, 1, 0, 16'h0000);
    vecs[5]  = mk(1, 0, 1, 0, 16'h0000);
    vecs[6]  = mk(1, 1, 1, 1, 16'h0005);
    vecs[7]  = mk(1, 1, 1, 1, 16'h0005);
    vecs[8]  = mk(0, 0, 0, 0, 16'h0005);
    vecs[9]  = mk(0, 1, 0, 1, 16'h0005);
    vecs[10] = mk(0, 1, 0, 1, 16'h0005);
    vecs[11] = mk(0, 1, 0, 1, 16'h0005);
    vecs[12] = mk(1, 1, 1, 1, 16'hFFFD);
    vecs[13] = mk(1, 1, 1, 1, 16'hFFFD);
    vecs[14] = mk(0, 0, 0, 0, 16'hFFFD);
    vecs[15] = mk(1, 1, 1, 1, 16'h0000);
    vecs[16] = mk(0, 0, 1, 1, 16'h0000);
    vecs[17] = mk(0, 0, 0, 0, 16'h0000);
    vecs[18] = mk(1, 1, 1, 1, 16'h0000);
    vecs[19] = mk(0, 0, 1, 1, 16'h0000);
    vecs[20] = mk(1, 0, 0, 0, 16'h0000);
    vecs[21] = mk(1, 0, 0, 0, 16'h0000);
    vecs[22] = mk(0, 0, 0, 0, 16'h0000);
    vecs[23] = mk(1, 0, 1, 0, 16'h0000);
    vecs[24] = mk(1, 1, 1, 1, 16'h0001);
    vecs[25] = mk(0, 0, 1, 1, 16'h0001);
    vecs[26] = mk(0, 0, 0, 0, 16'h0001);

    m_n = 0;
    model_reset();
    bus.input_ref_digital = 1'b0;
    bus.input_fb_digital  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_up",   16'(bus.output_up_digital),   16'd0);
    chk("reset_down", 16'(bus.output_down_digital), 16'd0);
    chk("reset_err",  bus.output_phase_err_real,    16'd0);
    chk("reset_lock", 16'(bus.output_lock_digital), 16'd0);

    // Directed table: ref lead 5, fb lead 3, simultaneous, ref edge lost in BOTH.
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].r, vecs[i].f);
      chk($sformatf("tbl%0d_up", i),   16'(bus.output_up_digital),   16'(vecs[i].up));
      chk($sformatf("tbl%0d_down", i), 16'(bus.output_down_digital), 16'(vecs[i].dn));
      chk($sformatf("tbl%0d_err", i),  bus.output_phase_err_real,    vecs[i].err);
    end

    // Asynchronous reset in the middle of an up pulse, ref still high afterwards.
    step(1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0);
    chk("pre_reset_up", 16'(bus.output_up_digital), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_up",   16'(bus.output_up_digital),   16'd0);
    chk("async_down", 16'(bus.output_down_digital), 16'd0);
    chk("async_err",  bus.output_phase_err_real,    16'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("held_high_no_up", 16'(bus.output_up_digital), 16'd0);
    end

    // Lock: clear, 16 in-window comparisons, then one out-of-window.
    do_compare(1'b1, 9);
    chk("lock_cleared", 16'(bus.output_lock_digital), 16'd0);
    for (int i = 0; i < 16; i++) begin
      do_compare(i[0], 2);
      if (i == 14) chk("lock_15th", 16'(bus.output_lock_digital), 16'd0);
      if (i == 15) chk("lock_16th", 16'(bus.output_lock_digital), 16'(LOCK_BUILT));
    end
    do_compare(1'b1, 9);
    chk("lock_drop_err9", bus.output_phase_err_real, 16'd9);
    chk("lock_drop", 16'(bus.output_lock_digital), 16'd0);

    // Lone pulse longer than the width counter range.
    step(1'b0, 1'b0);
    for (int i = 0; i < 66000; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("sat_err", bus.output_phase_err_real, 16'h7FFF);
    repeat (3) step(1'b0, 1'b0);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (4) step(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) do_compare(1'($urandom_range(0, 1)), $urandom_range(0, 7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_freq_detector_fp_int.md
# phase_freq_detector_fp_int

Event-driven phase-frequency detector for the PLL model. It compares rising edges of the reference and feedback (divider) signals and produces the 1-bit up/down pulse pair consumed by the charge pump's `input_up_digital` / `input_down_digital`. It also produces a signed fixed-point phase-error word and an optional lock indicator. It runs entirely on the system clock, with reference and feedback treated as sampled data.

## Interface
- `reset_delay_param`, default 2: cycles the BOTH (reset) state is held; dead-zone suppression; 0 is treated as 1.
- `lock_window_param`, default 4: maximum lone-pulse width, in cycles, counted as an in-lock comparison.
- `lock_count_param`, default 16: consecutive in-lock comparisons required to assert lock.
- `sys_clk`, input, 1: sole clock; all state updates on rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `input_ref_digital`, input, 1: reference signal, sampled on `sys_clk`.
- `input_fb_digital`, input, 1: feedback signal, sampled on `sys_clk`.
- `output_up_digital`, output, 1: charge-pump up request.
- `output_down_digital`, output, 1: charge-pump down request.
- `output_phase_err_real`, output, 16: signed phase error of the last comparison, in cycles.
- `output_lock_digital`, output, 1: lock indicator; tied 0 when the lock feature is compiled out.

## Operation
- Edge detect: `ref_q` and `fb_q` hold the previous samples. `ref_rise = input_ref_digital & ~ref_q`; `fb_rise` is formed the same way.
- FSM states are IDLE, UP, DOWN, BOTH. Outputs are registered from the state:
  - `up` = UP or BOTH.
  - `down` = DOWN or BOTH.
- IDLE transitions:
  - `ref_rise` only -> UP.
  - `fb_rise` only -> DOWN.
  - Both edges in the same cycle -> BOTH, with width 0.
- UP transitions: `fb_rise` -> BOTH. A repeated `ref_rise` is ignored and the state stays UP.
- DOWN transitions: `ref_rise` -> BOTH. A repeated `fb_rise` is ignored and the state stays DOWN.
- BOTH: `dly_cnt` loads `max(reset_delay_param,1)-1` on entry and decrements each cycle. At 0 the FSM goes to IDLE. Edges arriving during BOTH are dropped, because reset dominates.
- Width counter:
  - 16-bit unsigned.
  - Cleared on entry to UP or DOWN.
  - Increments every cycle spent in UP or DOWN.
  - Saturates at 65535.
- Phase error is registered on BOTH entry:
  - `+min(width+1, 32767)` if entered from UP.
  - `-min(width+1, 32767)` if entered from DOWN.
  - 0 if entered from IDLE.
  - Otherwise held.
- Lock (when compiled in): evaluated on each BOTH entry.
  - `|err| <= lock_window_param`: increment the in-lock count, saturating at `lock_count_param`. Lock asserts when the count reaches `lock_count_param`.
  - Otherwise: clear the count and deassert lock in the same update.
- Reset values:
  - State IDLE.
  - `ref_q` and `fb_q` = 0.
  - All outputs 0.
  - Counters 0.

## Timing
- Input-to-output latency is 1 edge. An input first sampled high at edge k produces an `up`/`down` change visible after edge k.
- The up pulse spans from the `ref_rise` edge to the `fb_rise` edge, plus `reset_delay_param` cycles of overlap in BOTH.
- `output_phase_err_real` and `output_lock_digital` update on the same edge as BOTH entry.
- An input held high produces no further edges, so there is no retrigger until the input has been seen low.
- Asserting `reset` mid-pulse forces IDLE and zero outputs immediately. After release, an input already high is not counted as an edge, because `ref_q`/`fb_q` capture it on the first clock.

## Configuration
- Macro: `PFD_LOCK_DETECT_EN`.
- Defined: the lock counter and comparator are instantiated, and `output_lock_digital` behaves as specified.
- Undefined: no lock logic is built, `output_lock_digital` is tied to 0, and `lock_window_param` / `lock_count_param` are unused.
- Up/down and phase-error behaviour is identical in both builds.

## Structure
- Package `pfd_pkg` holds:
  - The state enum (IDLE/UP/DOWN/BOTH) and its 2-bit encoding.
  - `PFD_WIDTH_W = 16`, `PFD_ERR_W = 16`, and the saturation constants 65535 / 32767.
- Sub-module `pfd_lock_detector` takes the BOTH-entry strobe and `|err|` as inputs and produces the lock flag. It is instantiated only under `PFD_LOCK_DETECT_EN`.

## Test plan
- Reference leads the feedback edge by 5 cycles with default parameters -> `up`=1 for 5+2 cycles, `down`=1 for 2 cycles, err=+5 after the comparison.
- Feedback leads by 3 cycles -> `down`-only for 3 cycles, then 2 cycles of BOTH, err=-3.
- Simultaneous edges -> BOTH for 2 cycles, `up`=`down`=1 together, err=0.
- A `ref_rise` arriving during BOTH -> dropped: the FSM returns to IDLE and `up` does not reassert until the next edge.
- 16 comparisons with err=±2 -> lock=1 on the 16th. One comparison with err=+9 -> lock=0 on that edge (with `PFD_LOCK_DETECT_EN`). Without the macro, lock stays 0 throughout.
- `reset` pulsed while in UP with width 10 -> outputs 0 asynchronously. The input held high after release produces no pulse. A lone-pulse width above 65535 cycles -> err saturates at +32767.
